// File: rtl/mic1_mem_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mic1_mem_sequencer_pkg
//   Shared definitions for the MIC-1 memory access sequencer:
//   - FSM state encodings (IDLE=0, DATA=1, FETCH=2)
//   - byte-lane geometry of the 32-bit memory word
//   - default and counter width for the bounded ack wait
// -----------------------------------------------------------------------------
package mic1_mem_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } seq_state_t;

    // A 32-bit word holds four bytes; PC[1:0] selects one of them.
    localparam int LANE_W         = 2;
    localparam int BYTES_PER_WORD = 4;

    // Bounded wait for mem_ack. WAIT_MAX must lie in 1..255 so it fits
    // the 8-bit wait counter.
    localparam int DEFAULT_WAIT_MAX = 15;
    localparam int WAIT_CNT_W       = 8;

endpackage

// File: rtl/mic1_mem_sequencer_wait_timer.sv
// -----------------------------------------------------------------------------
// mic1_mem_sequencer_wait_timer
//   Counts cycles a bus transaction has waited for mem_ack.
//   Ports:
//     clk     in  : clock, rising edge
//     rst     in  : asynchronous active-low reset
//     clr     in  : synchronous clear (wins over en)
//     en      in  : count one waited cycle
//     timeout out : high in the WAIT_MAX-th waited cycle of a transaction,
//                   i.e. the cycle after which the access must be aborted
// -----------------------------------------------------------------------------
module mic1_mem_sequencer_wait_timer
    import mic1_mem_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = DEFAULT_WAIT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    // The counter starts at 0 in the first request cycle, so the
    // WAIT_MAX-th cycle of waiting is the one where it holds WAIT_MAX-1.
    localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_MAX - 1);

    logic [WAIT_CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + WAIT_CNT_W'(1);
        end
    end

    // Depends only on en and the count, never on clr, so the parent may
    // fold timeout back into clr without a combinational loop.
    assign timeout = en && (count_reg == LAST_CNT);

endmodule

// File: rtl/mic1_mem_sequencer.sv
// -----------------------------------------------------------------------------
// mic1_mem_sequencer
//   Serialises the MIC-1 data port (rd/wr via MAR/MDR) and instruction fetch
//   port (fetch via PC/MBR) onto one 32-bit req/ack memory bus. A data access
//   always goes first; a fetch requested in the same microinstruction follows
//   it. stall holds MPC/MIR in the control path while an access is in flight.
//   Each transaction waits at most WAIT_MAX cycles for mem_ack before it is
//   aborted and the sticky err flag is raised.
//
//   Ports:
//     clk, rst             : clock; asynchronous active-low reset
//     rd, wr, fetch        : MIR memory requests, sampled only when idle
//     MAR                  : word address for rd/wr
//     PC                   : byte address for fetch
//     MDR_out              : write data
//     mem_req/mem_we       : bus request / write strobe
//     mem_addr, mem_wdata  : bus word address / write data (stable during req)
//     mem_ack, mem_rdata   : bus completion and read data (same cycle)
//     MDR_in, MDR_load     : read result and its one-cycle load pulse
//     MBR_in, MBR_load     : fetched byte and its one-cycle load pulse
//     stall                : high while an access is in flight
//     err                  : sticky error (rd+wr together, or ack timeout)
// -----------------------------------------------------------------------------
module mic1_mem_sequencer
    import mic1_mem_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = DEFAULT_WAIT_MAX,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic              fetch,
    input  logic [ADDR_W-1:0] MAR,
    input  logic [ADDR_W-1:0] PC,
    input  logic [31:0]       MDR_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       MDR_in,
    output logic              MDR_load,
    output logic [7:0]        MBR_in,
    output logic              MBR_load,
    output logic              stall,
    output logic              err
);

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    seq_state_t        state_reg;
    seq_state_t        state_next;

    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] fetch_addr_reg;
    logic              fetch_pend_reg;
    logic [LANE_W-1:0] lane_reg;
    logic [31:0]       mdr_in_reg;
    logic              mdr_load_reg;
    logic [7:0]        mbr_in_reg;
    logic              mbr_load_reg;
    logic              err_reg;

    logic              busy;
    logic              timeout;
    logic              abort;
    logic              timer_clr;
    logic [7:0]        rdata_byte [BYTES_PER_WORD];
    logic [7:0]        mbr_byte;

    // PC is a byte address; the bus is word addressed.
    function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] byte_addr);
        return {2'b00, byte_addr[ADDR_W-1:2]};
    endfunction

    // ---------------------------------------------------------------------
    // Wait timer: restarts at 0 in the first cycle of every transaction.
    // Clearing on ack also covers the DATA->FETCH hand-over, so the
    // follow-on fetch gets its own full WAIT_MAX budget.
    // ---------------------------------------------------------------------
    assign busy      = (state_reg != ST_IDLE);
    assign timer_clr = !busy || mem_ack || timeout;
    // A late ack in the final allowed cycle still completes the access.
    assign abort     = timeout && !mem_ack;

    mic1_mem_sequencer_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (busy),
        .timeout (timeout)
    );

    // ---------------------------------------------------------------------
    // Byte-lane mux: lane 0 = bits 7:0 ... lane 3 = bits 31:24
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        assign rdata_byte[gi] = mem_rdata[8*gi +: 8];
    end

    assign mbr_byte = rdata_byte[lane_reg];

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rd || wr) begin
                    state_next = ST_DATA;
                end else if (fetch) begin
                    state_next = ST_FETCH;
                end
            end
            ST_DATA: begin
                if (mem_ack) begin
                    state_next = fetch_pend_reg ? ST_FETCH : ST_IDLE;
                end else if (abort) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ack || abort) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs. Decoded straight from the state register so that an
    // asynchronous reset drops req/stall/we immediately.
    // ---------------------------------------------------------------------
    always_comb begin
        mem_req = 1'b0;
        stall   = 1'b0;
        mem_we  = 1'b0;
        case (state_reg)
            ST_DATA: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                mem_we  = we_reg;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                stall   = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Bus address/data latches, pending fetch, load pulses and error flag
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            we_reg         <= 1'b0;
            fetch_addr_reg <= '0;
            fetch_pend_reg <= 1'b0;
            lane_reg       <= '0;
            mdr_in_reg     <= '0;
            mdr_load_reg   <= 1'b0;
            mbr_in_reg     <= '0;
            mbr_load_reg   <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            // Load strobes are single-cycle by construction.
            mdr_load_reg <= 1'b0;
            mbr_load_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (rd || wr) begin
                        mem_addr_reg  <= MAR;
                        mem_wdata_reg <= MDR_out;
                        // With rd and wr both high the write wins.
                        we_reg        <= wr;
                        if (rd && wr) begin
                            err_reg <= 1'b1;
                        end
                        // Remember a simultaneous fetch; it runs after the
                        // data access completes.
                        fetch_pend_reg <= fetch;
                        if (fetch) begin
                            fetch_addr_reg <= PC;
                        end
                    end else if (fetch) begin
                        mem_addr_reg   <= word_of(PC);
                        lane_reg       <= PC[LANE_W-1:0];
                        we_reg         <= 1'b0;
                        fetch_pend_reg <= 1'b0;
                    end
                end

                ST_DATA: begin
                    if (mem_ack) begin
                        if (!we_reg) begin
                            mdr_in_reg   <= mem_rdata;
                            mdr_load_reg <= 1'b1;
                        end
                        if (fetch_pend_reg) begin
                            mem_addr_reg   <= word_of(fetch_addr_reg);
                            lane_reg       <= fetch_addr_reg[LANE_W-1:0];
                            we_reg         <= 1'b0;
                            fetch_pend_reg <= 1'b0;
                        end
                    end else if (abort) begin
                        err_reg        <= 1'b1;
                        fetch_pend_reg <= 1'b0;
                    end
                end

                ST_FETCH: begin
                    if (mem_ack) begin
                        mbr_in_reg   <= mbr_byte;
                        mbr_load_reg <= 1'b1;
                    end else if (abort) begin
                        err_reg <= 1'b1;
                    end
                end

                default: ;
            endcase
        end
    end

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign MDR_in    = mdr_in_reg;
    assign MDR_load  = mdr_load_reg;
    assign MBR_in    = mbr_in_reg;
    assign MBR_load  = mbr_load_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_mic1_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mic1_mem_sequencer
//   Directed bench for mic1_mem_sequencer (WAIT_MAX=3). Inputs change on the
//   falling edge, outputs are sampled on the falling edge; the DUT acts on the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_mic1_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, fetch = 1'b0;
    logic [31:0] MAR = '0, PC = '0, MDR_out = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req, mem_we, MDR_load, MBR_load, stall, err;
    logic [31:0] mem_addr, mem_wdata, MDR_in;
    logic [7:0]  MBR_in;

    int n_cmp = 0;
    int n_bad = 0;

    // Activity counters, sampled on every falling edge.
    int   stall_cyc = 0, mdr_pulses = 0, mbr_pulses = 0;
    int   overlap = 0, long_pulse = 0;
    logic prev_mdr = 1'b0, prev_mbr = 1'b0;

    int s_base, d_base, b_base;

    always #5 clk = ~clk;

    mic1_mem_sequencer #(
        .WAIT_MAX (3),
        .ADDR_W   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd        (rd),
        .wr        (wr),
        .fetch     (fetch),
        .MAR       (MAR),
        .PC        (PC),
        .MDR_out   (MDR_out),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .MDR_in    (MDR_in),
        .MDR_load  (MDR_load),
        .MBR_in    (MBR_in),
        .MBR_load  (MBR_load),
        .stall     (stall),
        .err       (err)
    );

    always @(negedge clk) begin
        if (stall)              stall_cyc  <= stall_cyc + 1;
        if (MDR_load)           mdr_pulses <= mdr_pulses + 1;
        if (MBR_load)           mbr_pulses <= mbr_pulses + 1;
        if (MDR_load && MBR_load) overlap  <= overlap + 1;
        if ((MDR_load && prev_mdr) || (MBR_load && prev_mbr)) long_pulse <= long_pulse + 1;
        prev_mdr <= MDR_load;
        prev_mbr <= MBR_load;
    end

    task automatic snap();
        s_base = stall_cyc;
        d_base = mdr_pulses;
        b_base = mbr_pulses;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #3;
        n_cmp++;
        if ({mem_req, mem_we, stall, err, MDR_load, MBR_load} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000000", {mem_req, mem_we, stall, err, MDR_load, MBR_load});
        end
        n_cmp++;
        if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        n_cmp++;
        if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        n_cmp++;
        if (MDR_in !== 32'h0) begin n_bad++; $display("FAIL reset_mdr_in: got %h want 0", MDR_in); end
        n_cmp++;
        if (MBR_in !== 8'h0) begin n_bad++; $display("FAIL reset_mbr_in: got %h want 0", MBR_in); end

        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        rd = 1'b1; MAR = 32'h30;
        @(negedge clk);
        rd = 1'b0;
        n_cmp++;
        if ({mem_req, stall} !== 2'b11) begin n_bad++; $display("FAIL reset_pre_req: got %b want 11", {mem_req, stall}); end
        #1 snap();
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, stall, err} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_async_drop: req/stall/err got %b want 000", {mem_req, stall, err});
        end
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (mdr_pulses - d_base !== 0) begin
            n_bad++;
            $display("FAIL reset_no_load: MDR_load pulses got %0d want 0", mdr_pulses - d_base);
        end
        $display("reset mid-read addr=0x30: req/stall dropped, no load");
    endtask

    // ------------------------------------------------------------------
    task automatic test_read();
        @(negedge clk); #1 snap();
        rd = 1'b1; MAR = 32'h10; mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, stall, mem_we} !== 3'b110) begin n_bad++; $display("FAIL read_req: req/stall/we got %b want 110", {mem_req, stall, mem_we}); end
        n_cmp++;
        if (mem_addr !== 32'h10) begin n_bad++; $display("FAIL read_addr: got %h want 10", mem_addr); end
        rd = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        n_cmp++;
        if ({mem_req, stall, MDR_load} !== 3'b001) begin n_bad++; $display("FAIL read_done: req/stall/MDR_load got %b want 001", {mem_req, stall, MDR_load}); end
        n_cmp++;
        if (MDR_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data: got %h want deadbeef", MDR_in); end
        @(negedge clk);
        n_cmp++;
        if (MDR_load !== 1'b0) begin n_bad++; $display("FAIL read_pulse_width: MDR_load got %b want 0", MDR_load); end
        @(negedge clk); #1;
        n_cmp++;
        if (stall_cyc - s_base !== 1) begin n_bad++; $display("FAIL read_stall_len: got %0d want 1", stall_cyc - s_base); end
        n_cmp++;
        if (mdr_pulses - d_base !== 1) begin n_bad++; $display("FAIL read_mdr_pulses: got %0d want 1", mdr_pulses - d_base); end
        $display("read addr=0x10 rdata=0x%h -> MDR_in=0x%h", 32'hDEADBEEF, MDR_in);
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        @(negedge clk); #1 snap();
        wr = 1'b1; fetch = 1'b1; MAR = 32'h4; MDR_out = 32'h12345678; PC = 32'h0000000B;
        mem_ack = 1'b0;
        @(negedge clk);                       // DATA cycle 1
        n_cmp++;
        if ({mem_req, mem_we} !== 2'b11) begin n_bad++; $display("FAIL b2b_wr_req: req/we got %b want 11", {mem_req, mem_we}); end
        n_cmp++;
        if (mem_addr !== 32'h4) begin n_bad++; $display("FAIL b2b_wr_addr: got %h want 4", mem_addr); end
        n_cmp++;
        if (mem_wdata !== 32'h12345678) begin n_bad++; $display("FAIL b2b_wr_wdata: got %h want 12345678", mem_wdata); end
        wr = 1'b0; fetch = 1'b0; MAR = 32'hFFF0; MDR_out = 32'h0; PC = 32'h0;
        @(negedge clk);                       // DATA cycle 2
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_we} !== {32'h4, 32'h12345678, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_wr_stable: addr %h wdata %h we %b want 4 12345678 1", mem_addr, mem_wdata, mem_we);
        end
        @(negedge clk);                       // DATA cycle 3: ack
        mem_ack = 1'b1; mem_rdata = 32'h99;
        @(negedge clk);                       // FETCH cycle 1
        mem_ack = 1'b0;
        n_cmp++;
        if ({mem_req, mem_we, MDR_load} !== 3'b100) begin n_bad++; $display("FAIL b2b_fetch_req: req/we/MDR_load got %b want 100", {mem_req, mem_we, MDR_load}); end
        n_cmp++;
        if (mem_addr !== 32'h2) begin n_bad++; $display("FAIL b2b_fetch_addr: got %h want 2", mem_addr); end
        @(negedge clk);                       // FETCH cycle 2
        @(negedge clk);                       // FETCH cycle 3: ack
        mem_ack = 1'b1; mem_rdata = 32'hA1B2C3D4;
        @(negedge clk);
        mem_ack = 1'b0;
        n_cmp++;
        if ({stall, MBR_load} !== 2'b01) begin n_bad++; $display("FAIL b2b_fetch_done: stall/MBR_load got %b want 01", {stall, MBR_load}); end
        n_cmp++;
        if (MBR_in !== 8'hA1) begin n_bad++; $display("FAIL b2b_lane3: MBR_in got %h want a1", MBR_in); end
        @(negedge clk); #1;
        n_cmp++;
        if (stall_cyc - s_base !== 6) begin n_bad++; $display("FAIL b2b_stall_len: got %0d want 6", stall_cyc - s_base); end
        n_cmp++;
        if ({mdr_pulses - d_base, mbr_pulses - b_base} !== {32'd0, 32'd1}) begin
            n_bad++;
            $display("FAIL b2b_pulses: MDR %0d MBR %0d want 0 1", mdr_pulses - d_base, mbr_pulses - b_base);
        end
        $display("write addr=0x4 wdata=0x12345678 then fetch PC=0xB -> MBR_in=0x%h", MBR_in);
    endtask

    // ------------------------------------------------------------------
    task automatic test_fetch();
        @(negedge clk); #1 snap();
        fetch = 1'b1; PC = 32'h1;
        @(negedge clk);                       // FETCH cycle 1
        n_cmp++;
        if ({mem_req, mem_we, stall} !== 3'b101) begin n_bad++; $display("FAIL fetch_req: req/we/stall got %b want 101", {mem_req, mem_we, stall}); end
        n_cmp++;
        if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL fetch_addr: got %h want 0", mem_addr); end
        rd = 1'b1; wr = 1'b1; fetch = 1'b1; PC = 32'h40; MAR = 32'h80;
        @(negedge clk);                       // FETCH cycle 2: ack
        rd = 1'b0; wr = 1'b0; fetch = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h0000AB00;
        @(negedge clk);
        mem_ack = 1'b0;
        n_cmp++;
        if ({MBR_load, MBR_in} !== {1'b1, 8'hAB}) begin n_bad++; $display("FAIL fetch_lane1: load/MBR_in got %b/%h want 1/ab", MBR_load, MBR_in); end
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0) begin n_bad++; $display("FAIL fetch_no_extra: mem_req got %b want 0", mem_req); end
        @(negedge clk); #1;
        n_cmp++;
        if (stall_cyc - s_base !== 2) begin n_bad++; $display("FAIL fetch_stall_len: got %0d want 2", stall_cyc - s_base); end
        n_cmp++;
        if ({mbr_pulses - b_base, mdr_pulses - d_base} !== {32'd1, 32'd0}) begin
            n_bad++;
            $display("FAIL fetch_pulses: MBR %0d MDR %0d want 1 0", mbr_pulses - b_base, mdr_pulses - d_base);
        end
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL fetch_err: got %b want 0", err); end
        $display("fetch PC=0x1 rdata=0x0000ab00 -> MBR_in=0x%h", MBR_in);
    endtask

    // ------------------------------------------------------------------
    task automatic test_ack_idle();
        @(negedge clk); #1 snap();
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        repeat (3) @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({stall_cyc - s_base, mdr_pulses - d_base, mbr_pulses - b_base} !== {32'd0, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL idle_ack: stall %0d MDR %0d MBR %0d want 0 0 0", stall_cyc - s_base, mdr_pulses - d_base, mbr_pulses - b_base);
        end
        n_cmp++;
        if (MDR_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL idle_ack_mdr: got %h want deadbeef", MDR_in); end
        $display("ack in idle: ignored");
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        @(negedge clk); #1 snap();
        rd = 1'b1; MAR = 32'h20; mem_ack = 1'b0;
        @(negedge clk);                       // cycle 1
        rd = 1'b0;
        @(negedge clk);                       // cycle 2
        @(negedge clk);                       // cycle 3
        n_cmp++;
        if ({stall, err} !== 2'b10) begin n_bad++; $display("FAIL timeout_last_wait: stall/err got %b want 10", {stall, err}); end
        @(negedge clk);
        n_cmp++;
        if ({stall, err, MDR_load} !== 3'b010) begin n_bad++; $display("FAIL timeout_abort: stall/err/MDR_load got %b want 010", {stall, err, MDR_load}); end
        @(negedge clk); #1;
        n_cmp++;
        if (stall_cyc - s_base !== 3) begin n_bad++; $display("FAIL timeout_stall_len: got %0d want 3", stall_cyc - s_base); end
        n_cmp++;
        if (mdr_pulses - d_base !== 0) begin n_bad++; $display("FAIL timeout_no_load: got %0d want 0", mdr_pulses - d_base); end
        $display("read addr=0x20 no ack -> aborted, err=%b", err);

        rd = 1'b1; MAR = 32'h24;
        @(negedge clk);
        rd = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({MDR_in, err} !== {32'h77, 1'b1}) begin n_bad++; $display("FAIL err_sticky: MDR_in %h err %b want 77 1", MDR_in, err); end
        $display("read addr=0x24 rdata=0x77 -> MDR_in=0x%h, err still %b", MDR_in, err);
    endtask

    // ------------------------------------------------------------------
    task automatic test_rd_wr_conflict();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL conflict_reset_err: got %b want 0", err); end
        @(negedge clk); #1 snap();
        rd = 1'b1; wr = 1'b1; MAR = 32'h8; MDR_out = 32'hCAFEF00D;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        n_cmp++;
        if ({mem_req, mem_we, err} !== 3'b111) begin n_bad++; $display("FAIL conflict_write: req/we/err got %b want 111", {mem_req, mem_we, err}); end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== {32'h8, 32'hCAFEF00D}) begin
            n_bad++;
            $display("FAIL conflict_bus: addr %h wdata %h want 8 cafef00d", mem_addr, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'h5555;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({stall, mdr_pulses - d_base} !== {1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL conflict_done: stall %b MDR pulses %0d want 0 0", stall, mdr_pulses - d_base);
        end
        $display("rd+wr addr=0x8 -> write issued, err=%b", err);
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_fetch();
        test_ack_idle();
        test_timeout();
        test_rd_wr_conflict();

        n_cmp++;
        if ({overlap, long_pulse} !== {32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL pulse_rules: overlapping %0d long %0d want 0 0", overlap, long_pulse);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
